// File: rtl/uart_inst_loader_if.sv
// Bus bundle between the UART byte source / debugger and the loader,
// plus the program-memory write port it drives.
interface uart_inst_loader_if #(
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  i_start;
  logic [7:0]            i_rx_data;
  logic                  i_rx_valid;
  logic                  o_inst_write_enable;
  logic [ADDR_WIDTH-1:0] o_write_addr;
  logic [SIZE-1:0]       o_write_data;
  logic                  o_writing;
  logic                  o_done;
  logic                  o_err;

  modport slave (
    input  i_start, i_rx_data, i_rx_valid,
    output o_inst_write_enable, o_write_addr,
    output o_write_data, o_writing, o_done, o_err
  );

  modport master (
    output i_start, i_rx_data, i_rx_valid,
    input  o_inst_write_enable, o_write_addr,
    input  o_write_data, o_writing, o_done, o_err
  );
endinterface

// File: rtl/uart_inst_loader.sv
// Packs UART bytes (count header, then big-endian words) into
// sequential program-memory writes starting at address 0.
module uart_inst_loader #(
  parameter int SIZE            = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int MAX_INSTRUCTION = 64,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input logic              i_clk,
  input logic              i_rst,
  uart_inst_loader_if.slave bus
);
  localparam int WIDX = $clog2(MAX_INSTRUCTION) + 1;
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_BYTES, S_DONE, S_ERR
  } state_t;

  state_t                r_state, w_state_d;
  logic [WIDX-1:0]       r_n, w_n_d;
  logic [WIDX-1:0]       r_idx, w_idx_d;
  logic [1:0]            r_bcnt, w_bcnt_d;
  logic [SIZE-9:0]       r_word, w_word_d;
  logic [TW-1:0]         r_tcnt, w_tcnt_d;
  logic                  r_we, w_we_d;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
  logic [SIZE-1:0]       r_data, w_data_d;
  logic                  r_writing, w_writing_d;
  logic                  r_done, w_done_d;
  logic                  r_err, w_err_d;
  logic [SIZE-1:0]       w_shift;
  logic                  w_timeout;
  logic                  w_bad_n;

  assign w_shift   = {r_word, bus.i_rx_data};
  assign w_timeout = (r_tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign w_bad_n   = (bus.i_rx_data == 8'd0) ||
    (32'(bus.i_rx_data) > 32'(MAX_INSTRUCTION));

  always_comb begin
    w_state_d   = r_state;
    w_n_d       = r_n;
    w_idx_d     = r_idx;
    w_bcnt_d    = r_bcnt;
    w_word_d    = r_word;
    w_tcnt_d    = r_tcnt;
    w_we_d      = 1'b0;
    w_addr_d    = r_addr;
    w_data_d    = r_data;
    w_writing_d = r_writing;
    w_done_d    = 1'b0;
    w_err_d     = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_state_d   = S_COUNT;
          w_err_d     = 1'b0;
          w_writing_d = 1'b1;
          w_tcnt_d    = '0;
        end
      end
      S_COUNT: begin
        if (bus.i_rx_valid) begin
          w_tcnt_d = '0;
          if (w_bad_n) begin
            w_state_d   = S_ERR;
            w_err_d     = 1'b1;
            w_writing_d = 1'b0;
          end else begin
            w_state_d = S_BYTES;
            w_n_d     = WIDX'(bus.i_rx_data);
            w_idx_d   = '0;
            w_bcnt_d  = '0;
          end
        end else if (w_timeout) begin
          w_state_d   = S_ERR;
          w_err_d     = 1'b1;
          w_writing_d = 1'b0;
        end else begin
          w_tcnt_d = r_tcnt + TW'(1);
        end
      end
      S_BYTES: begin
        if (bus.i_rx_valid) begin
          w_tcnt_d = '0;
          w_word_d = w_shift[SIZE-9:0];
          w_bcnt_d = r_bcnt + 2'd1;
          if (r_bcnt == 2'd3) begin
            w_we_d   = 1'b1;
            w_addr_d = ADDR_WIDTH'(r_idx) << 2;
            w_data_d = w_shift;
            w_idx_d  = r_idx + WIDX'(1);
            if (r_idx + WIDX'(1) == r_n)
              w_state_d = S_DONE;
          end
        end else if (w_timeout) begin
          w_state_d   = S_ERR;
          w_err_d     = 1'b1;
          w_writing_d = 1'b0;
        end else begin
          w_tcnt_d = r_tcnt + TW'(1);
        end
      end
      // Write strobe of the last word is live in this cycle
      S_DONE: begin
        w_state_d   = S_IDLE;
        w_done_d    = 1'b1;
        w_writing_d = 1'b0;
      end
      S_ERR:   w_state_d = S_IDLE;
      default: w_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_n       <= '0;
      r_idx     <= '0;
      r_bcnt    <= '0;
      r_word    <= '0;
      r_tcnt    <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_writing <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_n       <= w_n_d;
      r_idx     <= w_idx_d;
      r_bcnt    <= w_bcnt_d;
      r_word    <= w_word_d;
      r_tcnt    <= w_tcnt_d;
      r_we      <= w_we_d;
      r_addr    <= w_addr_d;
      r_data    <= w_data_d;
      r_writing <= w_writing_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
    end
  end

  assign bus.o_inst_write_enable = r_we;
  assign bus.o_write_addr        = r_addr;
  assign bus.o_write_data        = r_data;
  assign bus.o_writing           = r_writing;
  assign bus.o_done              = r_done;
  assign bus.o_err               = r_err;
endmodule
